rx_word_aligner_10b: RTL and testbench



---
 rtl/rx_word_aligner_10b_if.sv | 26 ++
 rtl/rx_word_aligner_10b.sv | 172 +++++++++++++++++
 tb/tb_rx_word_aligner_10b.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_word_aligner_10b_if.sv
// Receive-side bus for the 10-bit word aligner.
// Handshake: rawValid qualifies rawIn for one clkPara cycle and there is no
// back-pressure (the aligner accepts every valid word); dataValid qualifies
// dataOut and isComma for exactly the cycle it is high. fsmState mirrors the
// aligner's lock state machine (0=HUNT, 1=VERIFY, 2=LOCKED) for observation.
interface rx_word_aligner_10b_if;
  logic [9:0] rawIn;
  logic       rawValid;
  logic [9:0] dataOut;
  logic       dataValid;
  logic       isComma;
  logic       locked;
  logic [3:0] lockOffset;
  logic [7:0] relockCnt;
  logic [1:0] fsmState;

  modport master (
    output rawIn, rawValid,
    input  dataOut, dataValid, isComma, locked, lockOffset, relockCnt, fsmState
  );

  modport slave (
    input  rawIn, rawValid,
    output dataOut, dataValid, isComma, locked, lockOffset, relockCnt, fsmState
  );
endinterface

// File: rtl/rx_word_aligner_10b.sv
// Comma-based word aligner: searches a 20-bit window of two consecutive raw
// words for a comma at any of 10 bit offsets, locks to that offset through a
// HUNT/VERIFY/LOCKED machine, and emits realigned words one cycle later.
module rx_word_aligner_10b #(
  parameter logic [9:0] COMMA_P    = 10'b0011111010,
  parameter logic [9:0] COMMA_N    = 10'b1100000101,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 4
) (
  input logic                   clkPara,
  input logic                   resetN,
  rx_word_aligner_10b_if.slave  bus
);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] LOCK_TH = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TH = 4'(LOSS_COUNT);

  state_t      state, next_state;
  logic [9:0]  prev_word;
  logic        prev_valid;
  logic [3:0]  good_cnt, next_good;
  logic [3:0]  bad_cnt, next_bad;
  logic [3:0]  lock_off, next_off;
  logic [7:0]  relock, next_relock;

  logic [19:0] win;
  logic [9:0]  cand [10];
  logic [9:0]  hit;
  logic        any_hit;
  logic [3:0]  first_hit;
  logic        hit_lock;
  logic [9:0]  cand_lock;

  logic [9:0]  data_q, d_data;
  logic        valid_q, d_valid;
  logic        comma_q, d_comma;
  logic        locked_q;

  assign win = {prev_word, bus.rawIn};

  // Candidate symbols at every offset, comma detection and lowest-offset priority.
  always_comb begin
    any_hit   = 1'b0;
    first_hit = 4'd0;
    hit_lock  = 1'b0;
    cand_lock = 10'd0;
    hit       = 10'd0;
    for (int k = 0; k < 10; k++) begin
      cand[k] = win[19-k -: 10];
      hit[k]  = prev_valid && bus.rawValid &&
                ((cand[k] == COMMA_P) || (cand[k] == COMMA_N));
    end
    for (int k = 9; k >= 0; k--) begin
      if (hit[k]) first_hit = 4'(k);
    end
    for (int k = 0; k < 10; k++) begin
      if (lock_off == 4'(k)) begin
        hit_lock  = hit[k];
        cand_lock = cand[k];
      end
    end
    any_hit = |hit;
  end

  // State, counters and window history register.
  always_ff @(posedge clkPara) begin
    if (!resetN) begin
      state      <= HUNT;
      prev_word  <= 10'd0;
      prev_valid <= 1'b0;
      good_cnt   <= 4'd0;
      bad_cnt    <= 4'd0;
      lock_off   <= 4'd0;
      relock     <= 8'd0;
    end else begin
      state    <= next_state;
      good_cnt <= next_good;
      bad_cnt  <= next_bad;
      lock_off <= next_off;
      relock   <= next_relock;
      if (bus.rawValid) begin
        prev_word  <= bus.rawIn;
        prev_valid <= 1'b1;
      end
    end
  end

  // Lock state machine: only a valid word can move it.
  always_comb begin
    next_state  = state;
    next_good   = good_cnt;
    next_bad    = bad_cnt;
    next_off    = lock_off;
    next_relock = relock;
    if (bus.rawValid) begin
      unique case (state)
        HUNT: begin
          if (any_hit) begin
            next_off  = first_hit;
            next_good = 4'd1;
            if (LOCK_TH == 4'd1) begin
              next_state = LOCKED;
              next_bad   = 4'd0;
            end else begin
              next_state = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (hit_lock) begin
            next_good = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_TH) begin
              next_state = LOCKED;
              next_bad   = 4'd0;
            end
          end else if (any_hit) begin
            next_state = HUNT;
            next_good  = 4'd0;
          end
        end
        LOCKED: begin
          if (hit_lock) begin
            next_bad = 4'd0;
          end else if (any_hit) begin
            if (bad_cnt + 4'd1 == LOSS_TH) begin
              next_state = HUNT;
              next_good  = 4'd0;
              next_bad   = 4'd0;
              if (relock != 8'hFF) next_relock = relock + 8'd1;
            end else begin
              next_bad = bad_cnt + 4'd1;
            end
          end
        end
        default: next_state = HUNT;
      endcase
    end
  end

  // Data path decode: realigned word is produced only from a LOCKED state.
  always_comb begin
    d_valid = bus.rawValid && (state == LOCKED);
    d_comma = d_valid && hit_lock;
    d_data  = d_valid ? cand_lock : data_q;
  end

  // Output registers; locked follows the next state so it rises with the lock edge.
  always_ff @(posedge clkPara) begin
    if (!resetN) begin
      data_q   <= 10'd0;
      valid_q  <= 1'b0;
      comma_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      data_q   <= d_data;
      valid_q  <= d_valid;
      comma_q  <= d_comma;
      locked_q <= (next_state == LOCKED);
    end
  end

  assign bus.dataOut    = data_q;
  assign bus.dataValid  = valid_q;
  assign bus.isComma    = comma_q;
  assign bus.locked     = locked_q;
  assign bus.lockOffset = lock_off;
  assign bus.relockCnt  = relock;
  assign bus.fsmState   = state;

endmodule

// File: tb/tb_rx_word_aligner_10b.sv
// Bench for rx_word_aligner_10b: a serial bit stream is built from symbols at
// chosen bit offsets, cut into 10-bit words, and every cycle the outputs are
// compared with a bit-stream reference model.
module tb_rx_word_aligner_10b;

  localparam logic [9:0] CP = 10'b0011111010;
  localparam logic [9:0] CN = 10'b1100000101;
  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_word_aligner_10b_if bus();

  rx_word_aligner_10b #(
    .COMMA_P(CP), .COMMA_N(CN), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)
  ) dut (
    .clkPara(clk),
    .resetN (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // rxq holds the received bits in wire order (earliest first), at most the
  // last 20 while a word is being evaluated.
  bit         rxq[$];
  int         m_mode;   // 0 hunting, 1 verifying, 2 locked
  int         m_off, m_good, m_bad, m_relock;
  logic [9:0] m_data;
  logic       m_dv, m_isc, m_locked;

  // ---------------- transmit stream ----------------
  bit         txq[$];
  int         pushed = 0;
  bit         last_bit = 1'b0;
  bit         gap_mode = 1'b0;
  logic [9:0] fill_tab [6] = '{10'h155, 10'h2AA, 10'h333, 10'h0CC, 10'h199, 10'h266};

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] win_at(int k);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[9-i] = rxq[k+i];
    return w;
  endfunction

  task automatic model_edge(input logic [9:0] raw, input logic v, input logic r);
    int first;
    bit any, at_lock;
    logic [9:0] w;
    if (!r) begin
      rxq.delete();
      m_mode = 0; m_off = 0; m_good = 0; m_bad = 0; m_relock = 0;
      m_data = 10'd0; m_dv = 1'b0; m_isc = 1'b0; m_locked = 1'b0;
    end else if (!v) begin
      m_dv = 1'b0;
      m_isc = 1'b0;
    end else begin
      for (int i = 9; i >= 0; i--) rxq.push_back(raw[i]);
      first = -1; any = 1'b0; at_lock = 1'b0;
      if (rxq.size() == 20) begin
        for (int k = 0; k < 10; k++) begin
          w = win_at(k);
          if (w == CP || w == CN) begin
            any = 1'b1;
            if (first < 0) first = k;
            if (k == m_off) at_lock = 1'b1;
          end
        end
      end
      if (m_mode == 2) begin
        m_data = win_at(m_off);
        m_isc  = at_lock;
        m_dv   = 1'b1;
      end else begin
        m_dv  = 1'b0;
        m_isc = 1'b0;
      end
      case (m_mode)
        0: if (any) begin
             m_off = first;
             m_good = 1;
             if (LOCK_COUNT == 1) begin m_mode = 2; m_bad = 0; end
             else m_mode = 1;
           end
        1: if (at_lock) begin
             m_good++;
             if (m_good == LOCK_COUNT) begin m_mode = 2; m_bad = 0; end
           end else if (any) begin
             m_mode = 0;
             m_good = 0;
           end
        default: if (at_lock) m_bad = 0;
           else if (any) begin
             m_bad++;
             if (m_bad == LOSS_COUNT) begin
               m_mode = 0; m_good = 0; m_bad = 0;
               if (m_relock < 255) m_relock++;
             end
           end
      endcase
      m_locked = (m_mode == 2);
      while (rxq.size() > 10) void'(rxq.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [9:0] raw, input logic v, input logic r);
    @(negedge clk);
    bus.rawIn = raw;
    bus.rawValid = v;
    rst_n = r;
    @(posedge clk);
    model_edge(raw, v, r);
    #1;
    chk("dataOut",    bus.dataOut,              m_data);
    chk("dataValid",  10'(bus.dataValid),       10'(m_dv));
    chk("isComma",    10'(bus.isComma),         10'(m_isc));
    chk("locked",     10'(bus.locked),          10'(m_locked));
    chk("lockOffset", 10'(bus.lockOffset),      10'(m_off));
    chk("relockCnt",  10'(bus.relockCnt),       10'(m_relock));
  endtask

  task automatic flush();
    logic [9:0] word;
    while (txq.size() >= 10) begin
      for (int i = 9; i >= 0; i--) word[i] = txq.pop_front();
      step(word, 1'b1, 1'b1);
      if (gap_mode) step(10'($urandom), 1'b0, 1'b1);
    end
  endtask

  task automatic push_sym(input logic [9:0] sym);
    for (int i = 9; i >= 0; i--) txq.push_back(sym[i]);
    last_bit = sym[0];
    pushed += 10;
    flush();
  endtask

  // Insert alternating filler bits so the next symbol starts at bit offset o.
  task automatic set_offset(input int o);
    while (pushed % 10 != o) begin
      last_bit = ~last_bit;
      txq.push_back(last_bit);
      pushed++;
    end
  endtask

  task automatic rand_fill();
    push_sym(fill_tab[$urandom_range(0, 5)]);
  endtask

  task automatic pair(input logic [9:0] c);
    push_sym(c);
    rand_fill();
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) step(10'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.rawIn = 10'd0;
    bus.rawValid = 1'b0;

    // Aligned lock at offset 0, COMMA_P alternating with 10'h155.
    reset_cycles(3);
    chk("rst_dataOut",   bus.dataOut, 10'd0);
    chk("rst_locked",    10'(bus.locked), 10'd0);
    chk("rst_state",     10'(bus.fsmState), 10'd0);
    for (int i = 0; i < 6; i++) begin
      push_sym(CP);
      push_sym(10'h155);
      if (i == 2) chk("p1_not_yet_locked", 10'(bus.locked), 10'd0);
      if (i == 3) chk("p1_locked_4th", 10'(bus.locked), 10'd1);
    end
    chk("p1_offset", 10'(bus.lockOffset), 10'd0);
    chk("p1_data_comma", bus.dataOut, CP);
    chk("p1_is_comma", 10'(bus.isComma), 10'd1);
    push_sym(CP);
    chk("p1_data_fill", bus.dataOut, 10'h155);
    chk("p1_fill_not_comma", 10'(bus.isComma), 10'd0);

    // Offset 3 after a fresh reset.
    reset_cycles(2);
    set_offset(3);
    for (int i = 0; i < 6; i++) pair(CP);
    chk("p2_locked", 10'(bus.locked), 10'd1);
    chk("p2_offset", 10'(bus.lockOffset), 10'd3);
    chk("p2_relock", 10'(bus.relockCnt), 10'd0);

    // False lock at offset 6 abandoned for offset 2.
    reset_cycles(1);
    set_offset(6);
    push_sym(CN);
    rand_fill();
    chk("p3_verify", 10'(bus.fsmState), 10'd1);
    chk("p3_verify_off", 10'(bus.lockOffset), 10'd6);
    set_offset(2);
    pair(CP);
    chk("p3_back_hunt", 10'(bus.fsmState), 10'd0);
    for (int i = 0; i < 5; i++) pair(CP);
    chk("p3_locked", 10'(bus.locked), 10'd1);
    chk("p3_offset", 10'(bus.lockOffset), 10'd2);

    // Three misaligned commas then an aligned one keep lock.
    set_offset(7);
    for (int i = 0; i < 3; i++) pair(CN);
    chk("p4_hold_3bad", 10'(bus.locked), 10'd1);
    set_offset(2);
    pair(CP);
    chk("p4_hold_cleared", 10'(bus.locked), 10'd1);
    // Four consecutive misaligned commas drop lock, then relock at 7.
    set_offset(7);
    for (int i = 0; i < 4; i++) begin
      pair(CP);
      if (i == 2) chk("p4_still_locked", 10'(bus.locked), 10'd1);
    end
    chk("p4_lost", 10'(bus.locked), 10'd0);
    chk("p4_relock_cnt", 10'(bus.relockCnt), 10'd1);
    for (int i = 0; i < 5; i++) pair(CP);
    chk("p4_relocked", 10'(bus.locked), 10'd1);
    chk("p4_relock_off", 10'(bus.lockOffset), 10'd7);

    // Alternating valid/idle cycles while locked.
    gap_mode = 1'b1;
    for (int i = 0; i < 6; i++) pair(CN);
    gap_mode = 1'b0;
    chk("p5_locked", 10'(bus.locked), 10'd1);
    chk("p5_offset", 10'(bus.lockOffset), 10'd7);

    // Move to offset 5, then a single-cycle reset mid-run.
    set_offset(5);
    for (int i = 0; i < 10; i++) pair(CP);
    chk("p6_locked", 10'(bus.locked), 10'd1);
    chk("p6_offset", 10'(bus.lockOffset), 10'd5);
    chk("p6_relock_cnt", 10'(bus.relockCnt), 10'd2);
    step(10'($urandom), 1'b1, 1'b0);
    chk("p6_rst_locked", 10'(bus.locked), 10'd0);
    chk("p6_rst_valid", 10'(bus.dataValid), 10'd0);
    chk("p6_rst_data", bus.dataOut, 10'd0);
    chk("p6_rst_offset", 10'(bus.lockOffset), 10'd0);
    chk("p6_rst_relock", 10'(bus.relockCnt), 10'd0);
    chk("p6_rst_state", 10'(bus.fsmState), 10'd0);
    for (int i = 0; i < 6; i++) pair(CP);
    chk("p6_relocked", 10'(bus.locked), 10'd1);
    chk("p6_relock_off", 10'(bus.lockOffset), 10'd5);

    // Random mix of commas, random words, offset jumps and gaps.
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      gap_mode = ($urandom_range(0, 3) == 0);
      if (r < 2) set_offset($urandom_range(0, 9));
      if (r < 6) push_sym(r[0] ? CP : CN);
      else push_sym(10'($urandom));
      if ($urandom_range(0, 49) == 0) reset_cycles(1);
    end
    gap_mode = 1'b0;
    for (int i = 0; i < 3; i++) step(10'($urandom), 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
